alu_muldiv: RTL

//  Parametrised execute-stage ALU with an attached iterative multiply/divide unit and HI/LO registers.

---
 rtl/alu_muldiv_pkg.sv | 35 +++
 rtl/alu_muldiv_if.sv | 30 +++
 rtl/alu_muldiv_muldiv_iter.sv | 136 +++++++++++++
 rtl/alu_muldiv.sv | 108 ++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the execute-stage ALU and its iterative multiply/divide unit.
// Optional MADD/MADDU support is enabled by defining ALU_MULDIV_MADD_EN.
package alu_muldiv_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_MOVZ = 4'h7;
    localparam logic [3:0] ALU_SRA  = 4'h8;
    localparam logic [3:0] ALU_NOR  = 4'h9;
    localparam logic [3:0] ALU_SLT  = 4'hA;
    localparam logic [3:0] ALU_SLTU = 4'hB;
    localparam logic [3:0] ALU_LUI  = 4'hC;
    localparam logic [3:0] ALU_SLLV = 4'hD;
    localparam logic [3:0] ALU_SRLV = 4'hE;
    localparam logic [3:0] ALU_SRAV = 4'hF;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MADD  = 3'd4;
    localparam logic [2:0] MD_MADDU = 3'd5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIN  = 2'd2
    } md_state_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// Operand, result and multiply/divide handshake bundle between the EX stage and alu_muldiv.
interface alu_muldiv_if #(parameter int WIDTH = 32);

    logic [WIDTH-1:0]         a;
    logic [WIDTH-1:0]         b;
    logic [$clog2(WIDTH)-1:0] shamt;
    logic [3:0]               alu_op;
    logic [WIDTH-1:0]         result;
    logic                     b_zero;
    logic                     ovf;
    logic                     md_start;
    logic [2:0]               md_op;
    logic                     md_busy;
    logic                     md_done;
    logic                     hi_we;
    logic                     lo_we;
    logic [WIDTH-1:0]         hi;
    logic [WIDTH-1:0]         lo;

    modport master (
        output a, b, shamt, alu_op, md_start, md_op, hi_we, lo_we,
        input  result, b_zero, ovf, md_busy, md_done, hi, lo
    );

    modport slave (
        input  a, b, shamt, alu_op, md_start, md_op, hi_we, lo_we,
        output result, b_zero, ovf, md_busy, md_done, hi, lo
    );

endinterface

// File: rtl/alu_muldiv_muldiv_iter.sv
// Radix-2 iterative multiply / restoring divide with sign fix-up; one bit per cycle.
// ALU_MULDIV_MADD_EN makes MADD/MADDU legal and exposes the accumulate flag.
//
// state   | meaning
// MD_IDLE | waiting for a legal start; operands latched on accept
// MD_RUN  | WIDTH shift-add / shift-subtract steps, cnt_q counts down to 0
// MD_FIN  | signed result presented, done pulses, HI/LO written on this edge
module muldiv_iter
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             accept,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
`ifdef ALU_MULDIV_MADD_EN
    ,
    output logic             acc
`endif
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_q, step;
    logic [WIDTH-1:0]   mcand_q;
    logic               is_div_q, neg_a_q, neg_b_q, bz_q;
    logic [WIDTH-1:0]   a_q;
    logic               legal, sgn, div, na, nb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum, shl, dif;
    logic [2*WIDTH-1:0] prod_fix;
    logic               neg_p;

    always_comb begin
        legal = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef ALU_MULDIV_MADD_EN
        legal = legal || (op == MD_MADD) || (op == MD_MADDU);
`endif
    end

    assign accept = (state_q == MD_IDLE) && start && legal;
    assign busy   = (state_q == MD_RUN);
    assign done   = (state_q == MD_FIN);

    assign sgn   = (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD);
    assign div   = (op == MD_DIV) || (op == MD_DIVU);
    assign na    = sgn & a[WIDTH-1];
    assign nb    = sgn & b[WIDTH-1];
    assign mag_a = na ? -a : a;
    assign mag_b = nb ? -b : b;

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend-shifting-to-quotient}.
    always_comb begin
        add_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        shl     = prod_q[2*WIDTH-1:WIDTH-1];
        dif     = shl - {1'b0, mcand_q};
        if (!is_div_q)
            step = {add_sum, prod_q[WIDTH-1:1]};
        else if (dif[WIDTH])
            step = {shl[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        else
            step = {dif[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (accept) state_d = MD_RUN;
            MD_RUN:  if (cnt_q == '0) state_d = MD_FIN;
            MD_FIN:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            bz_q     <= 1'b0;
`ifdef ALU_MULDIV_MADD_EN
            acc      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q    <= CW'(WIDTH - 1);
                prod_q   <= div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                mcand_q  <= div ? mag_b : mag_a;
                a_q      <= a;
                is_div_q <= div;
                neg_a_q  <= na;
                neg_b_q  <= nb;
                bz_q     <= (b == '0);
`ifdef ALU_MULDIV_MADD_EN
                acc      <= (op == MD_MADD) || (op == MD_MADDU);
`endif
            end else if (state_q == MD_RUN) begin
                prod_q <= step;
                cnt_q  <= cnt_q - 1'b1;
            end
        end
    end

    // Divide by zero bypasses the fix-up: quotient all ones, remainder is the raw dividend.
    assign neg_p    = neg_a_q ^ neg_b_q;
    assign prod_fix = neg_p ? -prod_q : prod_q;

    always_comb begin
        if (!is_div_q) begin
            {res_hi, res_lo} = prod_fix;
        end else if (bz_q) begin
            res_hi = a_q;
            res_lo = '1;
        end else begin
            res_lo = neg_p   ? -prod_q[WIDTH-1:0]       : prod_q[WIDTH-1:0];
            res_hi = neg_a_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU (combinational) plus HI/LO registers fed by the iterative muldiv_iter unit.
// Define ALU_MULDIV_MADD_EN to add MADD/MADDU accumulation into {hi,lo}.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset_n,
    alu_muldiv_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0]   a, b, sum, dif, result_c;
    logic [SHW-1:0]     sv;
    logic               ovf_c;
    logic               md_accept, md_busy, md_done;
    logic [WIDTH-1:0]   res_hi, res_lo, hi_q, lo_q;
    logic [2*WIDTH-1:0] wr_val;

    assign a   = bus.a;
    assign b   = bus.b;
    assign sv  = a[SHW-1:0];
    assign sum = a + b;
    assign dif = a - b;

    always_comb begin
        result_c = '0;
        ovf_c    = 1'b0;
        case (bus.alu_op)
            ALU_ADD: begin
                result_c = sum;
                ovf_c    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result_c = dif;
                ovf_c    = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  result_c = a & b;
            ALU_OR:   result_c = a | b;
            ALU_XOR:  result_c = a ^ b;
            ALU_SLL:  result_c = b << bus.shamt;
            ALU_SRL:  result_c = b >> bus.shamt;
            ALU_MOVZ: result_c = a;
            ALU_SRA:  result_c = $signed(b) >>> bus.shamt;
            ALU_NOR:  result_c = ~(a | b);
            ALU_SLT:  result_c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result_c = {{(WIDTH-1){1'b0}}, a < b};
            ALU_LUI:  result_c = b << (WIDTH / 2);
            ALU_SLLV: result_c = b << sv;
            ALU_SRLV: result_c = b >> sv;
            ALU_SRAV: result_c = $signed(b) >>> sv;
            default:  result_c = '0;
        endcase
    end

    assign bus.result = result_c;
    assign bus.ovf    = ovf_c;
    assign bus.b_zero = (b == '0);

`ifdef ALU_MULDIV_MADD_EN
    logic md_acc;
`endif

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (bus.md_start),
        .op      (bus.md_op),
        .a       (a),
        .b       (b),
        .accept  (md_accept),
        .busy    (md_busy),
        .done    (md_done),
        .res_hi  (res_hi),
        .res_lo  (res_lo)
`ifdef ALU_MULDIV_MADD_EN
        ,
        .acc     (md_acc)
`endif
    );

`ifdef ALU_MULDIV_MADD_EN
    assign wr_val = md_acc ? ({hi_q, lo_q} + {res_hi, res_lo}) : {res_hi, res_lo};
`else
    assign wr_val = {res_hi, res_lo};
`endif

    // MTHI/MTLO only land when the unit is idle and no new op is being accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_done) begin
            {hi_q, lo_q} <= wr_val;
        end else if (!md_busy && !md_accept) begin
            if (bus.hi_we) hi_q <= a;
            if (bus.lo_we) lo_q <= a;
        end
    end

    assign bus.md_busy = md_busy;
    assign bus.md_done = md_done;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

endmodule
